// File: rtl/cdb_issue_scheduler.sv
// Round-robin issue scheduler: reserves one CDB slot per grant in a shifting reservation register.
// Optional per-channel saturating grant/conflict counters are built when ISSUE_STATS_EN is defined.
module cdb_issue_scheduler #(
  parameter int                NUM_CH       = 4,
  parameter int                MAX_LAT      = 8,
  parameter int                LAT_W        = 4,
  parameter logic [NUM_CH-1:0] NONPIPE_MASK = 4'b1000,
  parameter int                CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ready,
  input  logic [NUM_CH*LAT_W-1:0]    cfg_lat,
  input  logic                       issue_hold,
  output logic [NUM_CH-1:0]          issue,
  output logic                       cdb_valid,
  output logic [$clog2(NUM_CH)-1:0]  cdb_sel,
  output logic [NUM_CH-1:0]          ch_busy,
  output logic [NUM_CH-1:0]          cfg_err,
  output logic [NUM_CH*CNT_W-1:0]    stat_issued,
  output logic [NUM_CH*CNT_W-1:0]    stat_conflict
);

  localparam int SEL_W = $clog2(NUM_CH);

  logic [MAX_LAT-1:0] slot_q, slot_d;
  logic [SEL_W-1:0]   owner_q [MAX_LAT];
  logic [SEL_W-1:0]   owner_d [MAX_LAT];
  logic [NUM_CH-1:0]  busy_q, busy_d;
  logic [SEL_W-1:0]   rr_q, rr_d;

  logic [LAT_W-1:0]   lat [NUM_CH];
  logic [NUM_CH-1:0]  slot_free;
  logic [NUM_CH-1:0]  elig;
  logic               grant_vld;
  logic [SEL_W-1:0]   grant_ch;
  logic [NUM_CH-1:0]  grant_oh;
  logic [LAT_W-1:0]   grant_lat;

  // slot[MAX_LAT] does not exist, so a channel at MAX_LAT always finds its slot free.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      lat[i]       = cfg_lat[i*LAT_W +: LAT_W];
      cfg_err[i]   = (lat[i] == '0) || (int'(lat[i]) > MAX_LAT);
      slot_free[i] = 1'b1;
      for (int k = 1; k < MAX_LAT; k++) begin
        if (int'(lat[i]) == k) slot_free[i] = ~slot_q[k];
      end
      // Gating with rst keeps issue low for the whole reset window.
      elig[i] = rst && ready[i] && !cfg_err[i] && slot_free[i] && !issue_hold &&
                !(NONPIPE_MASK[i] && busy_q[i]);
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = (int'(rr_q) + off) % NUM_CH;
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = SEL_W'(idx);
      end
    end
    grant_oh  = grant_vld ? (NUM_CH'(1) << grant_ch) : '0;
    grant_lat = lat[grant_ch];
  end

  // Next state: shift reservations, retire, then book the new grant's slot.
  always_comb begin
    slot_d = {1'b0, slot_q[MAX_LAT-1:1]};
    for (int k = 0; k < MAX_LAT-1; k++) owner_d[k] = owner_q[k+1];
    owner_d[MAX_LAT-1] = '0;
    busy_d = busy_q;
    rr_d   = rr_q;
    if (slot_q[0]) busy_d[owner_q[0]] = 1'b0;
    if (grant_vld) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        if (int'(grant_lat) == k + 1) begin
          slot_d[k]  = 1'b1;
          owner_d[k] = grant_ch;
        end
      end
      if (NONPIPE_MASK[grant_ch]) busy_d[grant_ch] = 1'b1;
      rr_d = (int'(grant_ch) == NUM_CH - 1) ? '0 : SEL_W'(grant_ch + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
      busy_q <= '0;
      rr_q   <= '0;
      for (int k = 0; k < MAX_LAT; k++) owner_q[k] <= '0;
    end else begin
      slot_q <= slot_d;
      busy_q <= busy_d;
      rr_q   <= rr_d;
      for (int k = 0; k < MAX_LAT; k++) owner_q[k] <= owner_d[k];
    end
  end

  always_comb begin
    issue     = grant_oh;
    cdb_valid = slot_q[0];
    cdb_sel   = slot_q[0] ? owner_q[0] : '0;
    ch_busy   = busy_q & NONPIPE_MASK;
  end

`ifdef ISSUE_STATS_EN
  logic [CNT_W-1:0] iss_cnt [NUM_CH];
  logic [CNT_W-1:0] cfl_cnt [NUM_CH];

  // A conflict is any ready, unheld cycle that ends without a grant to that channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        iss_cnt[i] <= '0;
        cfl_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant_oh[i] && (iss_cnt[i] != '1)) iss_cnt[i] <= iss_cnt[i] + 1'b1;
        if (ready[i] && !issue_hold && !grant_oh[i] && (cfl_cnt[i] != '1))
          cfl_cnt[i] <= cfl_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      stat_issued[i*CNT_W +: CNT_W]   = iss_cnt[i];
      stat_conflict[i*CNT_W +: CNT_W] = cfl_cnt[i];
    end
  end
`else
  assign stat_issued   = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Scoreboard bench for cdb_issue_scheduler: stimulus queues expected grants and CDB results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_cdb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ready;
  logic [15:0] cfg_lat;
  logic        issue_hold;
  logic [3:0]  issue;
  logic        cdb_valid;
  logic [1:0]  cdb_sel;
  logic [3:0]  ch_busy;
  logic [3:0]  cfg_err;
  logic [63:0] stat_issued;
  logic [63:0] stat_conflict;

  cdb_issue_scheduler #(
    .NUM_CH(4), .MAX_LAT(8), .LAT_W(4), .NONPIPE_MASK(4'b1000), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .cfg_lat(cfg_lat), .issue_hold(issue_hold),
    .issue(issue), .cdb_valid(cdb_valid), .cdb_sel(cdb_sel), .ch_busy(ch_busy),
    .cfg_err(cfg_err), .stat_issued(stat_issued), .stat_conflict(stat_conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t q_iss[$];
  exp_t q_cdb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_iss(input int c, input int ch);
    exp_t e;
    e.cyc = c;
    e.val = 4'(1 << ch);
    q_iss.push_back(e);
  endtask

  task automatic push_cdb(input int c, input int ch);
    exp_t e;
    e.cyc = c;
    e.val = 4'(ch);
    q_cdb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    ready      = 4'b0000;
    issue_hold = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q_iss.size() > 0 && q_iss[0].cyc < cyc) begin
      e = q_iss.pop_front();
      n_cmp++; n_err++;
      $display("FAIL issue_missed: got nothing at cycle %0d, expected issue %b", e.cyc, e.val);
    end
    while (q_cdb.size() > 0 && q_cdb[0].cyc < cyc) begin
      e = q_cdb.pop_front();
      n_cmp++; n_err++;
      $display("FAIL cdb_missed: got nothing at cycle %0d, expected cdb_sel %0d", e.cyc, e.val);
    end
    if (issue != 4'b0000) begin
      n_cmp++;
      if (q_iss.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected at cycle %0d: got issue %b, expected none", cyc, issue);
      end else begin
        e = q_iss.pop_front();
        if (issue !== e.val || cyc != e.cyc) begin
          n_err++;
          $display("FAIL issue at cycle %0d: got %b, expected %b at cycle %0d", cyc, issue, e.val, e.cyc);
        end
      end
    end
    if (cdb_valid) begin
      n_cmp++;
      if (q_cdb.size() == 0) begin
        n_err++;
        $display("FAIL cdb_unexpected at cycle %0d: got cdb_sel %0d, expected none", cyc, cdb_sel);
      end else begin
        e = q_cdb.pop_front();
        if ({2'b00, cdb_sel} !== e.val || cyc != e.cyc) begin
          n_err++;
          $display("FAIL cdb at cycle %0d: got sel %0d, expected sel %0d at cycle %0d", cyc, cdb_sel, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected bench to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    ready      = 4'b1111;
    cfg_lat    = 16'h7411;
    issue_hold = 1'b0;

    // Reset state, with every queue ready to prove grants are held off.
    @(negedge clk);
    check("rst_issue",     64'(issue),     64'h0);
    check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    check("rst_cdb_sel",   64'(cdb_sel),   64'h0);
    check("rst_ch_busy",   64'(ch_busy),   64'h0);
    check("rst_cfg_err",   64'(cfg_err),   64'h0);
    check("rst_stat_iss",  stat_issued,    64'h0);
    do_reset();

    // Single ch0 instruction, latency 1.
    t0 = cyc;
    ready = 4'b0001;
    push_iss(t0, 0);
    push_cdb(t0 + 1, 0);
    tick();
    ready = 4'b0000;
    repeat (6) tick();

    // ch0/ch1 both ready: round-robin alternation, one grant per cycle.
    do_reset();
    t0 = cyc;
    ready = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      push_iss(t0 + k, k % 2);
      push_cdb(t0 + k + 1, k % 2);
    end
    repeat (6) tick();
    ready = 4'b0000;
    repeat (4) tick();

    // ch2 (lat 4) blocks ch0 (lat 1) at t=3.
    do_reset();
    t0 = cyc;
    ready = 4'b0100;
    push_iss(t0, 2);
    push_cdb(t0 + 4, 2);
    tick();
    ready = 4'b0000;
    tick();
    tick();
    ready = 4'b0001;
    @(negedge clk);
    check("s3_blocked_issue", 64'(issue), 64'h0);
    tick();
    push_iss(t0 + 4, 0);
    push_cdb(t0 + 5, 0);
    tick();
    ready = 4'b0000;
    repeat (4) tick();
`ifdef ISSUE_STATS_EN
    check("s3_stat_conflict0", 64'(stat_conflict[15:0]), 64'h1);
    check("s3_stat_issued2",   64'(stat_issued[47:32]),  64'h1);
`else
    check("s3_stat_conflict_tied", stat_conflict, 64'h0);
    check("s3_stat_issued_tied",   stat_issued,   64'h0);
`endif

    // Non-pipelined ch3 (lat 7): busy t1..t7, regrant at t8.
    do_reset();
    t0 = cyc;
    ready = 4'b1000;
    push_iss(t0, 3);
    push_cdb(t0 + 7, 3);
    push_iss(t0 + 8, 3);
    push_cdb(t0 + 15, 3);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("s4_ch_busy_t%0d", k), 64'(ch_busy),
            (k >= 1 && k <= 7) ? 64'h8 : 64'h0);
      tick();
    end
    ready = 4'b0000;
    repeat (9) tick();

    // Illegal latency on ch1.
    do_reset();
    cfg_lat = 16'h7401;
    ready   = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("s5_cfg_err", 64'(cfg_err), 64'h2);
      check("s5_issue",   64'(issue),   64'h0);
      tick();
    end
    ready   = 4'b0000;
    cfg_lat = 16'h7411;
    @(negedge clk);
    check("s5_cfg_err_clear", 64'(cfg_err), 64'h0);
    tick();

    // issue_hold while a ch2 result is in flight.
    do_reset();
    t0 = cyc;
    ready = 4'b0100;
    push_iss(t0, 2);
    push_cdb(t0 + 4, 2);
    tick();
    ready      = 4'b1111;
    issue_hold = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("s5_hold_issue", 64'(issue), 64'h0);
      tick();
    end
    ready      = 4'b0000;
    issue_hold = 1'b0;
    repeat (3) tick();

    // Reset mid-flight discards the ch2 reservation.
    do_reset();
    t0 = cyc;
    ready = 4'b0100;
    push_iss(t0, 2);
    tick();
    ready = 4'b0000;
    tick();
    rst   = 1'b0;
    ready = 4'b1111;
    @(negedge clk);
    check("s6_rst_issue",     64'(issue),     64'h0);
    check("s6_rst_cdb_valid", 64'(cdb_valid), 64'h0);
    check("s6_rst_cdb_sel",   64'(cdb_sel),   64'h0);
    check("s6_rst_ch_busy",   64'(ch_busy),   64'h0);
    tick();
    rst   = 1'b1;
    ready = 4'b0000;
    tick();
    @(negedge clk);
    check("s6_t4_cdb_valid", 64'(cdb_valid), 64'h0);
    repeat (4) tick();

    check("iss_queue_drained", 64'(q_iss.size()), 64'h0);
    check("cdb_queue_drained", 64'(q_cdb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_issue_scheduler.md
Name: cdb_issue_scheduler

Overview:
Parametrised successor of the fixed 4-queue issue unit. It arbitrates up to NUM_CH issue queues onto a single CDB using a shifting CDB reservation register. Each channel has a configurable execution latency and an optional non-pipelined mode. A round-robin grant replaces fixed priority, and the block emits the registered CDB mux select that cdb_logic consumes.

Parameters:
NUM_CH, 4, number of issue-queue/execution-unit channels (2..8)
MAX_LAT, 8, largest legal channel latency in cycles; reservation register depth
LAT_W, 4, width of each latency field; must hold MAX_LAT
NONPIPE_MASK, 4'b1000, bit i=1 marks channel i non-pipelined (divider style)
CNT_W, 16, statistics counter width (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ready  in  NUM_CH  bit i: queue i holds an instruction ready to issue
cfg_lat  in  NUM_CH*LAT_W  field i: latency of channel i; static while ready is nonzero
issue_hold  in  1  suppresses all grants this cycle; in-flight results still retire
issue  out  NUM_CH  one-hot grant to queue i (issueblk_done); combinational from state and inputs
cdb_valid  out  1  a result is on the CDB this cycle
cdb_sel  out  $clog2(NUM_CH)  channel driving the CDB this cycle; 0 when cdb_valid=0
ch_busy  out  NUM_CH  non-pipelined channel occupied
cfg_err  out  NUM_CH  field i is 0 or greater than MAX_LAT; channel i never granted
stat_issued  out  NUM_CH*CNT_W  see Optional Feature
stat_conflict  out  NUM_CH*CNT_W  see Optional Feature

Behaviour:
- State: slot[0..MAX_LAT-1] with owner[0..MAX_LAT-1]. slot[k]=1 means the CDB is claimed k cycles from now. Also rr_ptr and busy[NUM_CH].
- Reset (rst=0, asynchronous): slot, owner, busy, rr_ptr and counters go to 0. Outputs: issue=0, cdb_valid=0, cdb_sel=0, ch_busy=0.
- Eligibility of channel i, with L = cfg_lat[i]:
  - ready[i]=1
  - cfg_err[i]=0
  - slot[L]=0, where slot[MAX_LAT] is treated as 0
  - busy[i]=0 if the channel is in NONPIPE_MASK
  - issue_hold=0
- Grant: at most one per cycle. Search eligible channels starting at rr_ptr and wrap modulo NUM_CH. On a grant to channel g, rr_ptr becomes (g+1) mod NUM_CH. With no grant, rr_ptr holds.
- Shift each clock: slot_n[k]=slot[k+1] and owner_n[k]=owner[k+1]; slot_n[MAX_LAT-1]=0. On a grant to g with latency L, also set slot_n[L-1]=1 and owner_n[L-1]=g.
- Latency rule: a grant in cycle t puts cdb_valid=1 and cdb_sel=g in cycle t+L. L=1 gives a result on the next cycle.
- cdb_valid=slot[0]. cdb_sel=owner[0] when slot[0]=1, otherwise 0.
- busy[g] sets on a grant to a non-pipelined channel. It clears at the clock edge that ends the cycle where slot[0]=1 and owner[0]=g. Regrant is possible from the following cycle.
- Simultaneous events:
  - Retirement and a new grant to a different channel in the same cycle are both honoured.
  - Two ready channels with an equal free slot: the round-robin winner takes it. The loser is retried next cycle; because its latency slot shifts each cycle, it may then be blocked.
- issue_hold: in-flight slots keep shifting and retiring; busy clears normally.
- Reset mid-operation: all reservations are discarded immediately; no CDB output after rst falls.

Optional Feature:
ISSUE_STATS_EN. When defined, the block contains per-channel saturating counters:
- stat_issued[i] increments on each grant to channel i.
- stat_conflict[i] increments each cycle in which ready[i]=1, issue_hold=0 and channel i is not granted, whether blocked by a slot, busy or arbitration.
Counters saturate at all-ones and clear on reset. When the macro is undefined, there are no counters and stat_issued/stat_conflict are tied to 0.

Test Plan:
Common configuration: NUM_CH=4, lat = {7,4,1,1} (ch3..ch0), ch3 non-pipelined.
1. After reset, ready=4'b0001 for 1 cycle at t=0 -> issue=4'b0001 at t=0; cdb_valid=1, cdb_sel=0 at t=1; idle otherwise.
2. ready=4'b0011 held -> grants alternate ch0, ch1, ch0, …; cdb_sel alternates from the cycle after the first grant; no cycle has two grants.
3. ch2 granted at t=0, ch0 ready at t=3 -> ch0 blocked at t=3 (slot[1] taken); ch0 granted at t=4; CDB shows ch2 at t=4 and ch0 at t=5.
4. ch3 ready continuously -> granted at t=0; ch_busy[3]=1 for t=1..7; CDB shows ch3 at t=7; next grant at t=8.
5. cfg_lat ch1=0 and ready=4'b0010 -> cfg_err[1]=1; issue stays 0. Separately, issue_hold=1 during a ch2 in-flight result -> its CDB output still appears 4 cycles after the grant.
6. rst asserted at t=2 after a ch2 grant at t=0 -> no CDB output at t=4; all outputs 0. With ISSUE_STATS_EN defined, scenario 3 gives stat_conflict[0]=1 and stat_issued[2]=1.
